// File: rtl/uart_pkg.sv
// Shared UART types and constants used by the receive-side buffering logic.
package uart_pkg;

  typedef logic [7:0] byte_t;

  localparam byte_t ERR_COUNT_MAX      = 8'd255;
  localparam int    FIFO_DEPTH_DEFAULT = 8;

endpackage

// File: rtl/uart_sync_fifo.sv
// Generic DEPTH x 8 synchronous FIFO with a combinational head read and a
// drop pulse when a write arrives while full and no read frees a slot.
module uart_sync_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = FIFO_DEPTH_DEFAULT,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          nReset,
  input  logic          i_push,
  input  byte_t         i_data,
  input  logic          i_pop,
  output byte_t         o_data,
  output logic          o_valid,
  output logic [AW:0]   o_count,
  output logic          o_full,
  output logic          o_drop
);

  byte_t         r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;

  logic w_full;
  logic w_pop;
  logic w_wr;

  assign w_full = (r_count == (AW+1)'(DEPTH));
  assign w_pop  = i_pop && (r_count != '0);
  // A pop in the same clk frees the slot, so a full FIFO can still accept.
  assign w_wr   = i_push && (!w_full || w_pop);

  // NOTE: storage is reset here because the head byte is visible on o_data
  // and must read as zero straight out of reset.
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (w_wr) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  // NOTE: non-blocking assignments keep every register updating from the
  // pre-edge values, so pointer and count updates never race each other.
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr)  r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
      unique case ({w_wr, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_data  = r_mem[r_rd_ptr];
  assign o_valid = (r_count != '0);
  assign o_count = r_count;
  assign o_full  = w_full;
  assign o_drop  = i_push && w_full && !w_pop;

endmodule

// File: rtl/uart_rx_fifo.sv
// Receive buffer behind the UART receiver: edge-detects byte-complete and
// error levels, queues bytes, and keeps sticky overrun/framing status.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int Depth = FIFO_DEPTH_DEFAULT
) (
  input  logic                   clk,
  input  logic                   nReset,
  input  byte_t                  rxData,
  input  logic                   rxDone,
  input  logic                   rxErr,
  output byte_t                  outData,
  output logic                   outValid,
  input  logic                   outReady,
  output logic [$clog2(Depth):0] count,
  output logic                   full,
  output logic                   overrun,
  output logic                   frameErr,
  output byte_t                  errCount,
  input  logic                   clearFlags
);

  logic  r_done_prev;
  logic  r_err_prev;
  logic  r_overrun;
  logic  r_frame_err;
  byte_t r_err_count;

  logic  w_push;
  logic  w_err_ev;
  logic  w_drop;

  // Level inputs become single-clk events; a level high at reset release
  // counts as an edge because the history registers reset to 0.
  assign w_push   = rxDone && !r_done_prev;
  assign w_err_ev = rxErr && !r_err_prev;

  uart_sync_fifo #(.DEPTH(Depth)) u_fifo (
    .clk     (clk),
    .nReset  (nReset),
    .i_push  (w_push),
    .i_data  (rxData),
    .i_pop   (outReady),
    .o_data  (outData),
    .o_valid (outValid),
    .o_count (count),
    .o_full  (full),
    .o_drop  (w_drop)
  );

  // Set events take priority over clearFlags in the same clk.
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      r_done_prev <= 1'b0;
      r_err_prev  <= 1'b0;
      r_overrun   <= 1'b0;
      r_frame_err <= 1'b0;
      r_err_count <= '0;
    end else begin
      r_done_prev <= rxDone;
      r_err_prev  <= rxErr;

      if (w_drop)          r_overrun <= 1'b1;
      else if (clearFlags) r_overrun <= 1'b0;

      if (w_err_ev) begin
        r_frame_err <= 1'b1;
        if (clearFlags)                        r_err_count <= 8'd1;
        else if (r_err_count != ERR_COUNT_MAX) r_err_count <= r_err_count + 8'd1;
      end else if (clearFlags) begin
        r_frame_err <= 1'b0;
        r_err_count <= '0;
      end
    end
  end

  assign overrun  = r_overrun;
  assign frameErr = r_frame_err;
  assign errCount = r_err_count;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: a vector table for single-clk
// behaviour plus directed sequences for fill, overrun, wrap, and reset.
module tb_uart_rx_fifo;
  import uart_pkg::*;

  logic       clk;
  logic       nReset;
  byte_t      rxData;
  logic       rxDone;
  logic       rxErr;
  byte_t      outData;
  logic       outValid;
  logic       outReady;
  logic [3:0] count;
  logic       full;
  logic       overrun;
  logic       frameErr;
  byte_t      errCount;
  logic       clearFlags;

  int n_cmp  = 0;
  int n_fail = 0;

  uart_rx_fifo #(.Depth(8)) dut (
    .clk        (clk),
    .nReset     (nReset),
    .rxData     (rxData),
    .rxDone     (rxDone),
    .rxErr      (rxErr),
    .outData    (outData),
    .outValid   (outValid),
    .outReady   (outReady),
    .count      (count),
    .full       (full),
    .overrun    (overrun),
    .frameErr   (frameErr),
    .errCount   (errCount),
    .clearFlags (clearFlags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    byte_t      data;
    logic       done;
    logic       err;
    logic       rdy;
    logic       clr;
    byte_t      e_data;
    logic       e_valid;
    logic [3:0] e_count;
    logic       e_full;
    logic       e_ovr;
    logic       e_ferr;
    byte_t      e_ecnt;
  } vec_t;

  vec_t vecs [18];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    nReset     = 1'b0;
    rxData     = '0;
    rxDone     = 1'b0;
    rxErr      = 1'b0;
    outReady   = 1'b0;
    clearFlags = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    nReset = 1'b1;
  endtask

  task automatic push_byte(input byte_t b);
    rxData = b;
    rxDone = 1'b1;
    step();
    rxDone = 1'b0;
    step();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_data"},  32'(outData),  32'h0);
    check({tag, "_valid"}, 32'(outValid), 32'h0);
    check({tag, "_count"}, 32'(count),    32'h0);
    check({tag, "_full"},  32'(full),     32'h0);
    check({tag, "_ovr"},   32'(overrun),  32'h0);
    check({tag, "_ferr"},  32'(frameErr), 32'h0);
    check({tag, "_ecnt"},  32'(errCount), 32'h0);
  endtask

  initial begin
    int max_count;

    //          data  dn   er   rdy  clr   e_data v    cnt  f    ovr  fe   ecnt
    vecs[0]  = '{8'hA5, 1'b1, 1'b0, 1'b0, 1'b0, 8'hA5, 1'b1, 4'd1, 1'b0, 1'b0, 1'b0, 8'd0};
    vecs[1]  = '{8'hA5, 1'b1, 1'b0, 1'b0, 1'b0, 8'hA5, 1'b1, 4'd1, 1'b0, 1'b0, 1'b0, 8'd0};
    vecs[2]  = '{8'h5A, 1'b1, 1'b0, 1'b0, 1'b0, 8'hA5, 1'b1, 4'd1, 1'b0, 1'b0, 1'b0, 8'd0};
    vecs[3]  = '{8'h5A, 1'b1, 1'b0, 1'b0, 1'b0, 8'hA5, 1'b1, 4'd1, 1'b0, 1'b0, 1'b0, 8'd0};
    vecs[4]  = '{8'hA5, 1'b1, 1'b0, 1'b0, 1'b0, 8'hA5, 1'b1, 4'd1, 1'b0, 1'b0, 1'b0, 8'd0};
    vecs[5]  = '{8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'hA5, 1'b1, 4'd1, 1'b0, 1'b0, 1'b0, 8'd0};
    vecs[6]  = '{8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 8'd0};
    vecs[7]  = '{8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 8'd0};
    vecs[8]  = '{8'h3C, 1'b1, 1'b0, 1'b1, 1'b0, 8'h3C, 1'b1, 4'd1, 1'b0, 1'b0, 1'b0, 8'd0};
    vecs[9]  = '{8'h3C, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 8'd0};
    vecs[10] = '{8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 8'd1};
    vecs[11] = '{8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 8'd1};
    vecs[12] = '{8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 8'd1};
    vecs[13] = '{8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 8'd2};
    vecs[14] = '{8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 8'd2};
    vecs[15] = '{8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 8'h00, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 8'd1};
    vecs[16] = '{8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 8'h00, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 8'd0};
    vecs[17] = '{8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 8'd0};

    do_reset();
    check_all_zero("rst");

    for (int i = 0; i < 18; i++) begin
      rxData     = vecs[i].data;
      rxDone     = vecs[i].done;
      rxErr      = vecs[i].err;
      outReady   = vecs[i].rdy;
      clearFlags = vecs[i].clr;
      step();
      check($sformatf("v%0d_data", i),  32'(outData),  32'(vecs[i].e_data));
      check($sformatf("v%0d_valid", i), 32'(outValid), 32'(vecs[i].e_valid));
      check($sformatf("v%0d_count", i), 32'(count),    32'(vecs[i].e_count));
      check($sformatf("v%0d_full", i),  32'(full),     32'(vecs[i].e_full));
      check($sformatf("v%0d_ovr", i),   32'(overrun),  32'(vecs[i].e_ovr));
      check($sformatf("v%0d_ferr", i),  32'(frameErr), 32'(vecs[i].e_ferr));
      check($sformatf("v%0d_ecnt", i),  32'(errCount), 32'(vecs[i].e_ecnt));
    end
    rxDone = 1'b0; rxErr = 1'b0; outReady = 1'b0; clearFlags = 1'b0;

    // Fill to Depth, then a ninth byte is dropped.
    do_reset();
    for (int i = 1; i <= 8; i++) push_byte(byte_t'(i));
    check("fill_full", 32'(full), 32'h1);
    check("fill_count", 32'(count), 32'd8);
    check("fill_ovr_pre", 32'(overrun), 32'h0);
    push_byte(8'h09);
    check("ovr_set", 32'(overrun), 32'h1);
    check("ovr_count", 32'(count), 32'd8);
    outReady = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      check($sformatf("drain_%0d", i), 32'(outData), 32'(i));
      step();
    end
    check("drain_empty", 32'(outValid), 32'h0);
    outReady = 1'b0;

    // Full FIFO accepts a push that coincides with a pop.
    clearFlags = 1'b1;
    step();
    clearFlags = 1'b0;
    check("ovr_cleared", 32'(overrun), 32'h0);
    for (int i = 0; i < 8; i++) push_byte(8'h11 + byte_t'(i));
    check("refill_full", 32'(full), 32'h1);
    rxData   = 8'h55;
    rxDone   = 1'b1;
    outReady = 1'b1;
    step();
    rxDone   = 1'b0;
    outReady = 1'b0;
    check("pp_ovr", 32'(overrun), 32'h0);
    check("pp_count", 32'(count), 32'd8);
    outReady = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check($sformatf("pp_drain_%0d", i), 32'(outData),
            (i < 7) ? 32'(8'h12 + byte_t'(i)) : 32'h55);
      step();
    end
    check("pp_empty", 32'(outValid), 32'h0);

    // Streaming with outReady held high across pointer wrap.
    max_count = 0;
    for (int k = 0; k < 20; k++) begin
      rxData = 8'h40 + byte_t'(k);
      rxDone = 1'b1;
      step();
      rxDone = 1'b0;
      if (int'(count) > max_count) max_count = int'(count);
      check($sformatf("stream_v_%0d", k), 32'(outValid), 32'h1);
      check($sformatf("stream_d_%0d", k), 32'(outData), 32'(8'h40 + byte_t'(k)));
      repeat (2) begin
        step();
        if (int'(count) > max_count) max_count = int'(count);
      end
    end
    check("stream_max_count", 32'(max_count), 32'd1);
    check("stream_empty", 32'(outValid), 32'h0);
    outReady = 1'b0;

    // Long error pulses count once each, then the counter saturates.
    do_reset();
    repeat (3) begin
      rxErr = 1'b1;
      repeat (4) step();
      rxErr = 1'b0;
      repeat (2) step();
    end
    check("err3_cnt", 32'(errCount), 32'd3);
    check("err3_ferr", 32'(frameErr), 32'h1);
    check("err3_fifo", 32'(count), 32'd0);
    repeat (300) begin
      rxErr = 1'b1;
      step();
      rxErr = 1'b0;
      step();
    end
    check("err_sat", 32'(errCount), 32'd255);

    // Asynchronous reset with bytes queued and flags set.
    do_reset();
    for (int i = 0; i < 4; i++) push_byte(8'hC0 + byte_t'(i));
    rxErr = 1'b1;
    step();
    rxErr = 1'b0;
    check("pre_rst_count", 32'(count), 32'd4);
    check("pre_rst_ferr", 32'(frameErr), 32'h1);
    #2;
    nReset = 1'b0;
    #1;
    check_all_zero("midrst");
    @(negedge clk);
    nReset = 1'b1;
    step();
    check_all_zero("postrst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
